// File: rtl/add_acc.sv
// add_acc: frame accumulator built around an external 4-bit combinational adder.
//
// Takes N_SAMPLES unsigned 4-bit samples over a valid/ready handshake. While
// accumulating, the running sum is driven to the adder (add_a) together with
// the incoming sample (add_b), and the adder result is written back on each
// accepted sample. Carry-outs are counted in a saturating overflow counter.
// When the frame is complete, the result is held on an output valid/ready
// handshake until the consumer takes it.
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   clear               synchronous frame abort, overrides everything else
//   in_valid/in_ready   sample handshake (in_ready registered)
//   in_data[3:0]        sample value
//   add_a[3:0]          accumulator value, to adder input a
//   add_b[3:0]          copy of in_data, to adder input b
//   add_sum[3:0]        adder sum
//   add_carry           adder carry-out
//   out_valid/out_ready result handshake (out_valid registered)
//   out_sum[3:0]        low nibble of frame total
//   out_ovf[CNT_W-1:0]  carry count of the frame, saturating
module add_acc #(
    parameter int N_SAMPLES = 8,
    parameter int CNT_W     = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       in_data,
    output logic [3:0]       add_a,
    output logic [3:0]       add_b,
    input  logic [3:0]       add_sum,
    input  logic             add_carry,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [3:0]       out_sum,
    output logic [CNT_W-1:0] out_ovf
);

    typedef enum logic {
        ACC  = 1'b0,
        HOLD = 1'b1
    } state_t;

    localparam logic [7:0]       LAST_CNT = 8'(N_SAMPLES - 1);
    localparam logic [CNT_W-1:0] OVF_MAX  = '1;

    state_t           state_reg, state_next;
    logic [3:0]       acc_reg, acc_next;
    logic [CNT_W-1:0] ovf_reg, ovf_next;
    logic [7:0]       cnt_reg, cnt_next;
    logic             in_ready_reg, in_ready_next;
    logic             out_valid_reg, out_valid_next;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= ACC;
            acc_reg       <= '0;
            ovf_reg       <= '0;
            cnt_reg       <= '0;
            in_ready_reg  <= 1'b0;
            out_valid_reg <= 1'b0;
        end else begin
            state_reg     <= state_next;
            acc_reg       <= acc_next;
            ovf_reg       <= ovf_next;
            cnt_reg       <= cnt_next;
            in_ready_reg  <= in_ready_next;
            out_valid_reg <= out_valid_next;
        end
    end

    always_comb begin
        state_next     = state_reg;
        acc_next       = acc_reg;
        ovf_next       = ovf_reg;
        cnt_next       = cnt_reg;
        in_ready_next  = in_ready_reg;
        out_valid_next = out_valid_reg;

        if (clear) begin
            state_next     = ACC;
            acc_next       = '0;
            ovf_next       = '0;
            cnt_next       = '0;
            in_ready_next  = 1'b1;
            out_valid_next = 1'b0;
        end else begin
            case (state_reg)
                ACC: begin
                    // in_ready comes up on the first edge after reset and
                    // stays up for the whole accumulation phase.
                    in_ready_next = 1'b1;
                    if (in_valid && in_ready_reg) begin
                        acc_next = add_sum;
                        if (add_carry && (ovf_reg != OVF_MAX)) begin
                            ovf_next = ovf_reg + 1'b1;
                        end
                        if (cnt_reg == LAST_CNT) begin
                            state_next     = HOLD;
                            cnt_next       = '0;
                            in_ready_next  = 1'b0;
                            out_valid_next = 1'b1;
                        end else begin
                            cnt_next = cnt_reg + 8'd1;
                        end
                    end
                end
                HOLD: begin
                    if (out_valid_reg && out_ready) begin
                        state_next     = ACC;
                        acc_next       = '0;
                        ovf_next       = '0;
                        in_ready_next  = 1'b1;
                        out_valid_next = 1'b0;
                    end
                end
                default: begin
                    state_next = ACC;
                end
            endcase
        end
    end

    assign add_a     = acc_reg;
    assign add_b     = in_data;
    assign out_sum   = acc_reg;
    assign out_ovf   = ovf_reg;
    assign in_ready  = in_ready_reg;
    assign out_valid = out_valid_reg;

endmodule
